// File: rtl/icemem_arbiter.sv
// icemem_arbiter: shares the single-port icemem array between instruction
// fetch (port 0) and load/store (port 1). It uses round-robin arbitration and
// can hold the grant for locked read-modify-write sequences. Read data comes
// back on a registered response one cycle after the read beat.
module icemem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_we,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_clk_enable,
    input  logic [DATA_W-1:0] mem_output_data
);

    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        grant_s;
    logic              beat_s;
    logic              port_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_we_s;
    logic              sel_lock_s;

    // Grant selection: round-robin when free, only the owner while locked, nothing in reset.
    always_comb begin
        grant_s = 2'b00;
        case (state_q)
            ST_FREE: begin
                if (req_valid == 2'b11) begin
                    grant_s = last_q ? 2'b01 : 2'b10;
                end else if (req_valid[0]) begin
                    grant_s = 2'b01;
                end else if (req_valid[1]) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b00;
                end
            end
            ST_LOCK0: grant_s = {1'b0, req_valid[0]};
            ST_LOCK1: grant_s = {req_valid[1], 1'b0};
            default:  grant_s = 2'b00;
        endcase
        if (reset) begin
            grant_s = 2'b00;
        end else begin
            grant_s = grant_s;
        end
    end

    assign beat_s    = |grant_s;
    assign port_s    = grant_s[1];
    assign req_ready = grant_s;

    // Request mux: pick the attributes of the granted port.
    always_comb begin
        sel_addr_s  = req_addr0;
        sel_wdata_s = req_wdata0;
        sel_we_s    = req_we[0];
        sel_lock_s  = req_lock[0];
        if (port_s) begin
            sel_addr_s  = req_addr1;
            sel_wdata_s = req_wdata1;
            sel_we_s    = req_we[1];
            sel_lock_s  = req_lock[1];
        end else begin
            sel_addr_s  = req_addr0;
            sel_wdata_s = req_wdata0;
            sel_we_s    = req_we[0];
            sel_lock_s  = req_lock[0];
        end
    end

    // Next-state logic: lock tracking, round-robin pointer, held memory drive, read response.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 2'b00;
        resp_rdata_d = resp_rdata_q;
        if (beat_s) begin
            last_d  = port_s;
            addr_d  = sel_addr_s;
            wdata_d = sel_wdata_s;
            if (sel_lock_s) begin
                state_d = port_s ? ST_LOCK1 : ST_LOCK0;
            end else begin
                state_d = ST_FREE;
            end
            if (!sel_we_s) begin
                resp_valid_d = grant_s;
                resp_rdata_d = mem_output_data;
            end else begin
                resp_valid_d = 2'b00;
            end
        end else begin
            // A locked owner that goes idle gives up the lock.
            case (state_q)
                ST_LOCK0: state_d = req_valid[0] ? ST_LOCK0 : ST_FREE;
                ST_LOCK1: state_d = req_valid[1] ? ST_LOCK1 : ST_FREE;
                ST_FREE:  state_d = ST_FREE;
                default:  state_d = ST_FREE;
            endcase
        end
    end

    // State registers with synchronous reset; port 0 wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FREE;
            last_q       <= 1'b1;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= {DATA_W{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // During a beat the memory sees the live request; otherwise the last address and data are held.
    assign mem_read_address  = beat_s ? sel_addr_s : addr_q;
    assign mem_write_address = beat_s ? sel_addr_s : addr_q;
    assign mem_write_data    = beat_s ? sel_wdata_s : wdata_q;
    assign mem_write_enable  = beat_s & sel_we_s;
    assign mem_clk_enable    = beat_s & sel_we_s;
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = resp_rdata_q;

endmodule

// File: tb/tb_icemem_arbiter.sv
// Directed testbench for icemem_arbiter with a behavioural icemem model.
// Unwritten words read back as 32'hA5A5A5_<addr>.
module tb_icemem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_we, req_lock;
    logic [7:0]  req_addr0, req_addr1;
    logic [31:0] req_wdata0, req_wdata1;
    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic [7:0]  mem_read_address, mem_write_address;
    logic [31:0] mem_write_data, mem_output_data;
    logic        mem_write_enable, mem_clk_enable;

    int checks = 0;
    int errors = 0;

    bit [31:0] mem_m [256];
    bit        written_m [256];

    icemem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
        .mem_clk_enable(mem_clk_enable), .mem_output_data(mem_output_data)
    );

    always #5 clk = ~clk;

    // icemem model: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_write_enable && mem_clk_enable) begin
            mem_m[mem_write_address]     <= mem_write_data;
            written_m[mem_write_address] <= 1'b1;
        end
    end
    assign mem_output_data = written_m[mem_read_address] ? mem_m[mem_read_address]
                                                         : {24'hA5A5A5, mem_read_address};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
        req_addr0 = 8'h00; req_addr1 = 8'h00; req_wdata0 = 32'h0; req_wdata1 = 32'h0;

        // reset with both ports valid
        tick(); #4;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_ce", {31'd0, mem_clk_enable}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", {24'd0, mem_read_address}, 32'd0);

        // contention: continuous reads, port 0 first, alternating grants
        tick();
        reset = 1'b0; req_addr0 = 8'h10; req_addr1 = 8'h20;
        for (int k = 0; k < 6; k++) begin
            #4;
            chk("cont_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_addr", {24'd0, mem_read_address}, (k % 2 == 0) ? 32'h10 : 32'h20);
            if (k > 0) begin
                chk("cont_resp_valid", {30'd0, resp_valid}, (k % 2 == 1) ? 32'd1 : 32'd2);
                chk("cont_rdata", resp_rdata, (k % 2 == 1) ? 32'hA5A5A510 : 32'hA5A5A520);
            end else begin
                chk("cont_resp_first", {30'd0, resp_valid}, 32'd0);
            end
            tick();
        end
        req_valid = 2'b00; #4;
        chk("cont_idle_ready", {30'd0, req_ready}, 32'd0);
        chk("cont_last_resp", {30'd0, resp_valid}, 32'd2);
        chk("cont_last_rdata", resp_rdata, 32'hA5A5A520);
        tick();

        // read-after-write across ports
        req_valid = 2'b10; req_we = 2'b10; req_addr1 = 8'h05; req_wdata1 = 32'hDEADBEEF; #4;
        chk("raw_w_ready", {30'd0, req_ready}, 32'd2);
        chk("raw_w_we", {31'd0, mem_write_enable}, 32'd1);
        chk("raw_w_ce", {31'd0, mem_clk_enable}, 32'd1);
        chk("raw_w_addr", {24'd0, mem_write_address}, 32'h05);
        chk("raw_w_data", mem_write_data, 32'hDEADBEEF);
        tick();
        req_valid = 2'b01; req_we = 2'b00; req_addr0 = 8'h05; #4;
        chk("raw_r_ready", {30'd0, req_ready}, 32'd1);
        chk("raw_r_noresp", {30'd0, resp_valid}, 32'd0);
        chk("raw_r_we", {31'd0, mem_write_enable}, 32'd0);
        tick();
        req_valid = 2'b00; #4;
        chk("raw_resp_valid", {30'd0, resp_valid}, 32'd1);
        chk("raw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("raw_addr_hold", {24'd0, mem_read_address}, 32'h05);
        chk("raw_idle_ce", {31'd0, mem_clk_enable}, 32'd0);
        tick();

        // locked read-modify-write on port 1 while port 0 waits (last = 0)
        req_valid = 2'b11; req_addr0 = 8'h10; req_addr1 = 8'h30; req_lock = 2'b10; #4;
        chk("lock_rd_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_we = 2'b10; req_lock = 2'b00; req_wdata1 = 32'h12345678; #4;
        chk("lock_wr_ready", {30'd0, req_ready}, 32'd2);
        chk("lock_wr_we", {31'd0, mem_write_enable}, 32'd1);
        chk("lock_rd_resp", {30'd0, resp_valid}, 32'd2);
        chk("lock_rd_rdata", resp_rdata, 32'hA5A5A530);
        tick();
        req_valid = 2'b01; req_we = 2'b00; #4;
        chk("lock_p0_ready", {30'd0, req_ready}, 32'd1);
        chk("lock_p0_noresp", {30'd0, resp_valid}, 32'd0);
        tick();
        req_valid = 2'b00; #4;
        chk("lock_p0_resp", {30'd0, resp_valid}, 32'd1);
        chk("lock_p0_rdata", resp_rdata, 32'hA5A5A510);
        tick();

        // lock abandoned when port 1 drops valid
        req_valid = 2'b11; req_lock = 2'b10; #4;
        chk("aband_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b01; req_lock = 2'b00; #4;
        chk("aband_held", {30'd0, req_ready}, 32'd0);
        chk("aband_resp", resp_rdata, 32'h12345678);
        tick(); #4;
        chk("aband_free", {30'd0, req_ready}, 32'd1);
        tick();

        // LED word write
        req_valid = 2'b01; req_we = 2'b01; req_addr0 = 8'hFF; req_wdata0 = 32'h0000001F; #4;
        chk("led_we", {31'd0, mem_write_enable}, 32'd1);
        chk("led_ce", {31'd0, mem_clk_enable}, 32'd1);
        chk("led_addr", {24'd0, mem_write_address}, 32'hFF);
        tick();
        req_valid = 2'b00; req_we = 2'b00; #4;
        chk("led_idle_we", {31'd0, mem_write_enable}, 32'd0);
        chk("led_idle_ce", {31'd0, mem_clk_enable}, 32'd0);
        chk("led_mem", mem_m[8'hFF], 32'h0000001F);
        tick();

        // reset in the middle of a lock (last = 0)
        req_valid = 2'b11; req_lock = 2'b10; req_addr1 = 8'h30; #4;
        chk("rml_ready", {30'd0, req_ready}, 32'd2);
        tick();
        reset = 1'b1; #4;
        chk("rml_rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rml_rst_we", {31'd0, mem_write_enable}, 32'd0);
        tick();
        reset = 1'b0; req_lock = 2'b00; #4;
        chk("rml_after_ready", {30'd0, req_ready}, 32'd1);
        chk("rml_after_resp", {30'd0, resp_valid}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icemem_arbiter.md
# icemem_arbiter

Two-port arbiter that shares the single-port 256x32 `icemem` array between the instruction-fetch requester (port 0) and the load/store requester (port 1). It grants at most one access per cycle using round-robin with an optional lock for atomic read-modify-write sequences. It drives `icemem`'s address, data, write-enable and clock-enable inputs directly. Read data returns on a registered response one cycle after the grant.

## Interface
- `ADDR_W`, 8, address width; must match `icemem`.
- `DATA_W`, 32, data width; must match `icemem`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  per-port request valid; bit 0 is fetch, bit 1 is load/store.
- `req_we[1:0]`  in  2  per-port write flag; 1 = write, 0 = read.
- `req_lock[1:0]`  in  2  per-port lock; when set on a granted beat, the grant is held for the next beat.
- `req_addr0`, `req_addr1`  in  ADDR_W each  per-port address.
- `req_wdata0`, `req_wdata1`  in  DATA_W each  per-port write data.
- `req_ready[1:0]`  out  2  per-port grant; combinational, one-hot or zero.
- `resp_valid[1:0]`  out  2  per-port read response valid; registered.
- `resp_rdata`  out  DATA_W  read data; registered and shared by both ports.
- `mem_read_address`, `mem_write_address`  out  ADDR_W  to `icemem`.
- `mem_write_data`  out  DATA_W  to `icemem`.
- `mem_write_enable`, `mem_clk_enable`  out  1  to `icemem`.
- `mem_output_data`  in  DATA_W  combinational read data from `icemem`.

## Operation
- A beat is a cycle in which `req_valid[i] & req_ready[i]`. At most one beat occurs per cycle.
- States: FREE, LOCK0, LOCK1, plus a 1-bit round-robin pointer `last` giving the port granted most recently.
- **FREE:**
  - One port valid: that port is granted.
  - Both ports valid: the port other than `last` is granted.
  - Neither port valid: no grant.
- **LOCKi:** only port i may be granted. Port j is held with `req_ready[j]=0` even if valid.
- **Transitions:**
  - A beat on port i with `req_lock[i]=1` moves to LOCKi.
  - A beat on port i with `req_lock[i]=0` moves to FREE.
  - In LOCKi, if `req_valid[i]=0` for a cycle, the lock is abandoned and the state moves to FREE.
  - `last` updates to i on every beat of port i.
- **Memory drive during a beat on port i:**
  - `mem_read_address` = `mem_write_address` = `req_addr_i`.
  - `mem_write_data` = `req_wdata_i`.
  - `mem_write_enable` = `mem_clk_enable` = `req_we[i]`.
- **Memory drive with no beat:** `mem_write_enable`=0 and `mem_clk_enable`=0. Addresses hold their last value; no spurious write can occur.
- **Read beat:** `mem_output_data` is captured into `resp_rdata`, and `resp_valid[i]` is pulsed for exactly one cycle.
- **Write beat:** no response. The write is performed at the end of the beat cycle.
- Address 255 is the LED I/O word. It is treated as ordinary memory; no special casing.
- Responses cannot be back-pressured. Requesters must accept `resp_valid` whenever it is asserted.

## Timing
- **Reset** (synchronous, takes effect at the edge where `reset`=1):
  - State becomes FREE and `last` becomes 1, so port 0 wins the first contention.
  - `resp_valid`=0 and `resp_rdata`=0.
  - Address and data outputs become 0.
  - While `reset` is high, `req_ready`=0, `mem_write_enable`=0 and `mem_clk_enable`=0.
  - Reset mid-lock drops the lock.
- **Grant:** `req_ready` is combinational from `req_valid`, state and `last`, with no added latency.
- **Read latency:** a read beat in cycle N gives `resp_valid`/`resp_rdata` in cycle N+1.
- **Back-to-back:** reads can be issued every cycle, with one response per cycle.
- **Read-after-write:** a write beat in cycle N followed by a read beat of the same address in cycle N+1 returns the new data in N+2. This holds across ports.
- **Read-modify-write:** a locked read in cycle N followed by a write in cycle N+1 cannot be interleaved by the other port.
- `resp_rdata` holds its value when no read response is pending.

## Test plan
- **Reset:** assert `reset` with both ports valid → `req_ready`=00, `resp_valid`=00, `mem_write_enable`=0. Release `reset` → port 0 is granted first.
- **Contention:** both ports issue continuous reads of addresses 0x10 and 0x20 for 6 cycles → grants alternate 01,10,01,…. Each port gets 3 beats, and each `resp_valid` appears exactly 1 cycle after its grant.
- **Read-after-write:** port 1 writes 0xDEADBEEF to 0x05 in cycle N; port 0 reads 0x05 in cycle N+1 → `resp_rdata`=0xDEADBEEF with `resp_valid`=01 in cycle N+2.
- **Lock:** port 1 performs a locked read of 0x30 followed by an unlocked write of 0x30, with port 0 valid throughout → port 0 is stalled for both cycles and granted on the third. Dropping `req_valid[1]` while in LOCK1 releases the grant next cycle.
- **LED word:** write 0x0000001F to address 0xFF → `mem_write_enable`=`mem_clk_enable`=1 for exactly that cycle. An idle cycle afterwards keeps both at 0.
- **Reset mid-lock:** assert `reset` while in LOCK1 → after release, state is FREE and port 0 wins the first contention.
